// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target (i2c_slave) and the I2C
// controller (i2c_master).
//   - i2c_state_e      : target FSM state encoding
//   - I2C_ACK/I2C_NACK : SDA level during the acknowledge clock
//   - I2C_DEFAULT_ADDR : default 7-bit bus address
//   - addr_match()     : compares an address byte against a 7-bit address
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'b1001001;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  // The address byte carries the 7-bit address in [7:1] and R/W in [0].
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] own_addr);
    return addr_byte[7:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: brings SCL and SDA into the clk domain and detects bus
// events on the synchronized copies.
//   clk, rst   : system clock, synchronous active-high reset
//   scl, sda_in: raw bus lines (asynchronous)
//   sda_s      : synchronized SDA level
//   scl_rise   : one-clk pulse, synchronized SCL went 0 -> 1
//   scl_fall   : one-clk pulse, synchronized SCL went 1 -> 0
//   start      : one-clk pulse, SDA fell while SCL high
//   stop       : one-clk pulse, SDA rose while SCL high
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // Each pipe: [0] metastability stage, [1] synchronized, [2] history.
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;

  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl};
    sda_pipe_d = {sda_pipe_q[1:0], sda_in};
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, as real flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset to 1 = idle bus, so releasing reset never fakes an edge.
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
    end
  end

  logic scl_s, scl_h, sda_h;

  assign scl_s = scl_pipe_q[1];
  assign scl_h = scl_pipe_q[2];
  assign sda_s = sda_pipe_q[1];
  assign sda_h = sda_pipe_q[2];

  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  // SCL must be high on both samples so an SDA edge racing an SCL edge is
  // never mistaken for START/STOP.
  assign start    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop     = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target exposing 16-bit registers through a simple
// register-file strobe interface. No clock stretching.
//   clk, rst   : system clock, synchronous active-high reset
//   scl, sda_in: bus lines (asynchronous)
//   sda_oe     : 1 = pull SDA low, 0 = release
//   reg_addr   : register pointer (auto-increments after each 16-bit access)
//   reg_wdata  : write data, valid while reg_we = 1
//   reg_we     : one-clk write strobe
//   reg_re     : one-clk read strobe; reg_rdata sampled on the next clk
//   reg_rdata  : read data from the register file
//   busy       : 1 while this target is addressed
// Write frame: ADDR(W) PTR HI LO [HI LO ...]. Read frame: ADDR(R) HI LO ...
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda_in  (sda_in),
    .sda_s   (sda_s),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic        reg_re_q, reg_re_d;
  logic        busy_q, busy_d;
  logic        rw_q, rw_d;            // R/W bit of the address byte
  logic        byte_lo_q, byte_lo_d;  // 0 = high byte, 1 = low byte
  logic [7:0]  wdata_hi_q, wdata_hi_d;
  logic [7:0]  rdata_lo_q, rdata_lo_d;
  logic        rx_bit_q, rx_bit_d;    // controller ACK/NACK on reads

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      byte_lo_q   <= 1'b0;
      wdata_hi_q  <= '0;
      rdata_lo_q  <= '0;
      rx_bit_q    <= I2C_NACK;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      byte_lo_q   <= byte_lo_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_lo_q  <= rdata_lo_d;
      rx_bit_q    <= rx_bit_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    rw_d        = rw_q;
    byte_lo_d   = byte_lo_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_lo_d  = rdata_lo_q;
    rx_bit_d    = rx_bit_q;

    // The pointer advances one clk after the write strobe, so reg_we is
    // seen together with the address being written.
    if (reg_we_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end

    // Read data is captured one clk after reg_re; the high byte goes
    // straight into the shifter and its MSB onto SDA.
    if (reg_re_q && state_q == ST_RD_BYTE) begin
      shift_d    = reg_rdata[15:8];
      rdata_lo_d = reg_rdata[7:0];
      sda_oe_d   = ~reg_rdata[15];
    end

    unique case (state_q)
      ST_IDLE, ST_IGNORE: begin
        sda_oe_d = 1'b0;
      end

      ST_ADDR: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (addr_match(shift_q, SLAVE_ADDR)) begin
            state_d  = ST_ADDR_ACK;
            sda_oe_d = 1'b1;
            rw_d     = shift_q[0];
            busy_d   = 1'b1;
          end else begin
            state_d  = ST_IGNORE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
          end
        end
      end

      ST_ADDR_ACK: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
          byte_lo_d = 1'b0;
          if (rw_q) begin
            state_d  = ST_RD_BYTE;
            reg_re_d = 1'b1;
          end else begin
            state_d = ST_PTR;
          end
        end
      end

      ST_PTR: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          reg_addr_d = shift_q;
          sda_oe_d   = 1'b1;
          bit_cnt_d  = '0;
          state_d    = ST_PTR_ACK;
        end
      end

      ST_PTR_ACK: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          byte_lo_d = 1'b0;
          state_d   = ST_WR_BYTE;
        end
      end

      ST_WR_BYTE: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          sda_oe_d  = 1'b1;
          bit_cnt_d = '0;
          if (!byte_lo_q) begin
            wdata_hi_d = shift_q;
          end
          state_d = ST_WR_ACK;
        end
      end

      ST_WR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          // Only a completed low byte commits; a frame cut after the high
          // byte never reaches this point.
          if (byte_lo_q) begin
            reg_wdata_d = {wdata_hi_q, shift_q};
            reg_we_d    = 1'b1;
          end
          byte_lo_d = ~byte_lo_q;
          state_d   = ST_WR_BYTE;
        end
      end

      ST_RD_BYTE: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_RD_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
      end

      ST_RD_ACK: begin
        if (scl_rise) begin
          rx_bit_d = sda_s;
        end else if (scl_fall) begin
          if (rx_bit_q == I2C_ACK) begin
            state_d = ST_RD_BYTE;
            if (byte_lo_q) begin
              // Next register: the load path above refills the shifter.
              reg_addr_d = reg_addr_q + 8'd1;
              reg_re_d   = 1'b1;
              byte_lo_d  = 1'b0;
            end else begin
              shift_d   = rdata_lo_q;
              sda_oe_d  = ~rdata_lo_q[7];
              byte_lo_d = 1'b1;
            end
          end else begin
            state_d  = ST_IGNORE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        sda_oe_d = 1'b0;
      end
    endcase

    // Bus conditions override whatever the current state decided.
    if (stop) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a behavioural bus controller drives SCL/SDA
// (open-drain wired with the target's sda_oe) and a monitor logs strobes.
module tb_i2c_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_ctrl = 1'b1;
  logic        sda_oe;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata = 16'h0000;
  logic        busy;
  wire         sda_bus = sda_ctrl & ~sda_oe;

  int checks = 0;
  int errors = 0;

  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [7:0]  we_addr_log[$];
  logic [15:0] we_data_log[$];
  logic [7:0]  re_addr_log[$];
  logic        oe_seen = 1'b0;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      we_addr_log.push_back(reg_addr);
      we_data_log.push_back(reg_wdata);
    end
    if (reg_re) begin
      re_cnt++;
      re_addr_log.push_back(reg_addr);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda_ctrl = b; tick(4);
    scl = 1'b1;   tick(8);
    scl = 1'b0;   tick(4);
  endtask

  task automatic recv_bit(output logic b);
    sda_ctrl = 1'b1; tick(4);
    scl = 1'b1;      tick(4);
    b = sda_bus;     tick(4);
    scl = 1'b0;      tick(4);
  endtask

  task automatic start_cond();
    sda_ctrl = 1'b1; tick(4);
    scl = 1'b1;      tick(8);
    sda_ctrl = 1'b0; tick(8);
    scl = 1'b0;      tick(4);
  endtask

  task automatic stop_cond();
    sda_ctrl = 1'b0; tick(4);
    scl = 1'b1;      tick(8);
    sda_ctrl = 1'b1; tick(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(4);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
    checks++; if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_reg_re: got %b want 0", reg_re); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 16'h0000) begin errors++; $display("FAIL reset_reg_wdata: got %h want 0000", reg_wdata); end
    rst = 1'b0; tick(8);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int we0;
    we0 = we_cnt;
    start_cond();
    write_byte(8'h92, a0);
    write_byte(8'h96, a1);
    write_byte(8'hAA, a2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    write_byte(8'hCC, a3);
    stop_cond(); tick(4);
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b want 0", a0); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL write_ptr_ack: got %b want 0", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL write_hi_ack: got %b want 0", a2); end
    checks++; if (a3 !== 1'b0) begin errors++; $display("FAIL write_lo_ack: got %b want 0", a3); end
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL write_we_count: got %0d want 1", we_cnt - we0); end
    if (we_cnt - we0 == 1) begin
      checks++; if (we_addr_log[we0] !== 8'h96) begin errors++; $display("FAIL write_we_addr: got %h want 96", we_addr_log[we0]); end
      checks++; if (we_data_log[we0] !== 16'hAACC) begin errors++; $display("FAIL write_we_data: got %h want AACC", we_data_log[we0]); end
    end
    checks++; if (reg_addr !== 8'h97) begin errors++; $display("FAIL write_ptr_inc: got %h want 97", reg_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d_hi, d_lo;
    int re0;
    re0 = re_cnt;
    reg_rdata = 16'h1234;
    start_cond();
    write_byte(8'h92, a0);
    write_byte(8'h10, a1);
    start_cond();
    write_byte(8'h93, a2);
    read_byte(1'b0, d_hi);
    read_byte(1'b1, d_lo);
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", a2); end
    checks++; if (d_hi !== 8'h12) begin errors++; $display("FAIL read_hi_byte: got %h want 12", d_hi); end
    checks++; if (d_lo !== 8'h34) begin errors++; $display("FAIL read_lo_byte: got %h want 34", d_lo); end
    checks++; if (re_cnt - re0 !== 1) begin errors++; $display("FAIL read_re_count: got %0d want 1", re_cnt - re0); end
    if (re_cnt - re0 >= 1) begin
      checks++; if (re_addr_log[re0] !== 8'h10) begin errors++; $display("FAIL read_re_addr: got %h want 10", re_addr_log[re0]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack: got %b want 0", busy); end
    oe_seen = 1'b0;
    stop_cond(); tick(4);
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL read_ignore_oe: got %b want 0", oe_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read_burst();
    logic a0, a1, a2;
    logic [7:0] d0, d1, d2;
    int re0;
    re0 = re_cnt;
    reg_rdata = 16'hBEEF;
    start_cond();
    write_byte(8'h92, a0);
    write_byte(8'h40, a1);
    start_cond();
    write_byte(8'h93, a2);
    read_byte(1'b0, d0);
    read_byte(1'b0, d1);
    read_byte(1'b1, d2);
    stop_cond(); tick(4);
    checks++; if ({d0, d1, d2} !== 24'hBEEFBE) begin errors++; $display("FAIL burst_bytes: got %h want BEEFBE", {d0, d1, d2}); end
    checks++; if (re_cnt - re0 !== 2) begin errors++; $display("FAIL burst_re_count: got %0d want 2", re_cnt - re0); end
    if (re_cnt - re0 == 2) begin
      checks++; if (re_addr_log[re0 + 1] !== 8'h41) begin errors++; $display("FAIL burst_re_addr: got %h want 41", re_addr_log[re0 + 1]); end
    end
    checks++; if (reg_addr !== 8'h41) begin errors++; $display("FAIL burst_ptr: got %h want 41", reg_addr); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    oe_seen = 1'b0;
    start_cond();
    write_byte(8'h50, a0);
    write_byte(8'h96, a1);
    stop_cond(); tick(4);
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL mismatch_nack: got %b want 1", a0); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL mismatch_sda_oe: got %b want 0", oe_seen); end
    checks++; if (we_cnt - we0 !== 0 || re_cnt - re0 !== 0) begin errors++; $display("FAIL mismatch_strobes: got we=%0d re=%0d want 0 0", we_cnt - we0, re_cnt - re0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic a;
    int we0;
    we0 = we_cnt;
    start_cond();
    write_byte(8'h92, a);
    write_byte(8'hFF, a);
    write_byte(8'h11, a);
    write_byte(8'h22, a);
    write_byte(8'h33, a);
    write_byte(8'h44, a);
    stop_cond(); tick(4);
    checks++; if (we_cnt - we0 !== 2) begin errors++; $display("FAIL wrap_we_count: got %0d want 2", we_cnt - we0); end
    if (we_cnt - we0 == 2) begin
      checks++; if ({we_addr_log[we0], we_addr_log[we0 + 1]} !== 16'hFF00) begin errors++; $display("FAIL wrap_we_addr: got %h %h want FF 00", we_addr_log[we0], we_addr_log[we0 + 1]); end
      checks++; if ({we_data_log[we0], we_data_log[we0 + 1]} !== 32'h11223344) begin errors++; $display("FAIL wrap_we_data: got %h %h want 1122 3344", we_data_log[we0], we_data_log[we0 + 1]); end
    end
    checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr: got %h want 01", reg_addr); end
  endtask

  task automatic test_reset_mid();
    logic a;
    int we0;
    we0 = we_cnt;
    start_cond();
    write_byte(8'h92, a);
    write_byte(8'h20, a);
    send_bit(1'b1);
    sda_ctrl = 1'b0; tick(4);
    scl = 1'b1;      tick(4);
    rst = 1'b1;      tick(1);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_sda_oe: got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tick(2);
    sda_ctrl = 1'b1; tick(4);
    rst = 1'b0;      tick(8);
    checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL rstmid_no_we: got %0d want 0", we_cnt - we0); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rstmid_ptr: got %h want 00", reg_addr); end
    start_cond();
    write_byte(8'h92, a);
    write_byte(8'h30, a);
    write_byte(8'h55, a);
    write_byte(8'h66, a);
    stop_cond(); tick(4);
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL rstmid_recover_count: got %0d want 1", we_cnt - we0); end
    if (we_cnt - we0 == 1) begin
      checks++; if ({we_addr_log[we0], we_data_log[we0]} !== 24'h305566) begin errors++; $display("FAIL rstmid_recover_write: got %h %h want 30 5566", we_addr_log[we0], we_data_log[we0]); end
    end
  endtask

  task automatic test_stop_after_high();
    logic a;
    int we0;
    we0 = we_cnt;
    start_cond();
    write_byte(8'h92, a);
    write_byte(8'h40, a);
    write_byte(8'h77, a);
    stop_cond(); tick(4);
    checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL half_no_we: got %0d want 0", we_cnt - we0); end
    checks++; if (reg_addr !== 8'h40) begin errors++; $display("FAIL half_ptr: got %h want 40", reg_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_burst();
    test_mismatch();
    test_wrap();
    test_reset_mid();
    test_stop_after_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
